// File: rtl/md_if.sv
// md_if: request/result bundle between the EX stage and the multiply/divide unit
interface md_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       func;
  logic             is_sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  modport master(output start, func, is_sign, a, b, cancel, input hi, lo, busy, done);
  modport slave(input start, func, is_sign, a, b, cancel, output hi, lo, busy, done);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle MUL/DIV with HI/LO registers; MD_MADD_EN compiles in MADD/MSUB accumulate
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic rst,
  md_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1) > $clog2(MUL_LAT + 1) ? $clog2(WIDTH + 1) : $clog2(MUL_LAT + 1);
  typedef enum logic [2:0] {IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb, quo, rem, hi_r, lo_r, abs_a, abs_b, q_fix, r_fix;
  logic [WIDTH:0] shifted, trial;
  logic [2*WIDTH-1:0] ea, eb, prod, prod_q, mres, wb;
  logic sgn, fn_ok, accept, commit, done_r;
`ifdef MD_MADD_EN
  logic acc, sub;
  assign fn_ok = bus.func != 3'd0 && bus.func != 3'd7;
  assign mres  = !acc ? prod_q : sub ? {hi_r, lo_r} - prod_q : {hi_r, lo_r} + prod_q;
`else
  assign fn_ok = bus.func != 3'd0 && bus.func < 3'd5;
  assign mres  = prod_q;
`endif
  assign accept  = state == IDLE && bus.start && !bus.cancel && fn_ok;
  assign ea      = sgn ? {{WIDTH{sa[WIDTH-1]}}, sa} : {{WIDTH{1'b0}}, sa};
  assign eb      = sgn ? {{WIDTH{sb[WIDTH-1]}}, sb} : {{WIDTH{1'b0}}, sb};
  assign prod    = ea * eb;
  assign abs_a   = sgn && sa[WIDTH-1] ? -sa : sa;
  assign abs_b   = sgn && sb[WIDTH-1] ? -sb : sb;
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, abs_b};
  assign q_fix   = sgn && (sa[WIDTH-1] ^ sb[WIDTH-1]) ? -quo : quo;
  assign r_fix   = sgn && sa[WIDTH-1] ? -rem : rem;
  assign wb      = state == MUL ? mres : sb == '0 ? {sa, {WIDTH{1'b1}}} : {r_fix, q_fix};
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = state != IDLE;
  assign bus.done = done_r;
  generate
    if (MUL_LAT == 1) begin : g_comb
      assign prod_q = prod;
    end else begin : g_pipe
      logic [2*WIDTH-1:0] p [MUL_LAT-1];
      // product pipeline stages fed from the captured operands
      always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < MUL_LAT - 1; i++) p[i] <= '0;
        else begin
          p[0] <= prod;
          for (int i = 1; i < MUL_LAT - 1; i++) p[i] <= p[i-1];
        end
      end
      assign prod_q = p[MUL_LAT-2];
    end
  endgenerate
  // next state and commit strobe; cancel overrides everything while busy
  always_comb begin
    nxt    = state;
    commit = 1'b0;
    case (state)
      IDLE:     if (accept) nxt = bus.func == 3'd2 ? DIV_PREP : bus.func == 3'd3 || bus.func == 3'd4 ? IDLE : MUL;
      MUL:      if (cnt == CW'(MUL_LAT - 1)) begin nxt = IDLE; commit = 1'b1; end
      DIV_PREP: nxt = DIV_ITER;
      DIV_ITER: if (cnt == CW'(WIDTH - 1)) nxt = DIV_FIX;
      DIV_FIX:  begin nxt = IDLE; commit = 1'b1; end
      default:  nxt = IDLE;
    endcase
    if (bus.cancel && state != IDLE) begin
      nxt    = IDLE;
      commit = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // operand capture, divider iterations, HI/LO writes and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
      sgn    <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
`ifdef MD_MADD_EN
      acc    <= 1'b0;
      sub    <= 1'b0;
`endif
    end else begin
      done_r <= commit;
      cnt    <= state != nxt ? '0 : cnt + 1'b1;
      if (accept) begin
        sa  <= bus.a;
        sb  <= bus.b;
        sgn <= bus.is_sign;
`ifdef MD_MADD_EN
        acc <= bus.func != 3'd1;
        sub <= bus.func == 3'd6;
`endif
      end
      if (accept && bus.func == 3'd3) hi_r <= bus.a;
      if (accept && bus.func == 3'd4) lo_r <= bus.a;
      if (state == DIV_PREP) begin
        rem <= '0;
        quo <= abs_a;
      end
      if (state == DIV_ITER) begin
        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
      end
      if (commit) {hi_r, lo_r} <= wb;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit (WIDTH=32, MUL_LAT=3); honours MD_MADD_EN
module tb_md_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  logic [63:0] exp_q[$];
  md_if #(.WIDTH(32)) bus();
  md_unit #(.WIDTH(32), .MUL_LAT(3)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic op(input logic [2:0] f, input logic s, input logic [31:0] x, input logic [31:0] y);
    bus.start   = 1'b1;
    bus.func    = f;
    bus.is_sign = s;
    bus.a       = x;
    bus.b       = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  // monitor: every done pulse must match the oldest expected commit
  initial forever begin
    @(negedge clk);
    if (bus.done) begin
      if (exp_q.size() == 0) chk("unexpected_done", {bus.hi, bus.lo}, 64'hx);
      else chk("commit", {bus.hi, bus.lo}, exp_q.pop_front());
    end
  end
  initial begin
    bus.start = 1'b0; bus.func = 3'd0; bus.is_sign = 1'b0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("reset_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
    op(3'd1, 1'b1, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    chk("mul_s_latency", 64'(n), 64'd3);
    exp_q.push_back(64'h00000006_FFFFFFEB);
    op(3'd1, 1'b0, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    chk("mul_u_latency", 64'(n), 64'd3);
    exp_q.push_back({32'd2, 32'd14});
    op(3'd2, 1'b0, 32'd100, 32'd7);
    wait_idle(n);
    chk("div_latency", 64'(n), 64'd34);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    op(3'd2, 1'b1, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    exp_q.push_back(64'h00000005_FFFFFFFF);
    op(3'd2, 1'b0, 32'd5, 32'd0);
    wait_idle(n);
    exp_q.push_back(64'h00000000_80000000);
    op(3'd2, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    exp_q.push_back({32'd0, 32'd6});
    op(3'd1, 1'b0, 32'd2, 32'd3);
    op(3'd2, 1'b0, 32'd9, 32'd1);
    wait_idle(n);
    chk("busy_start_dropped", 64'(n), 64'd2);
    op(3'd3, 1'b0, 32'hDEADBEEF, 32'd0);
    chk("mthi_in_done_cycle", {bus.hi, bus.lo}, {32'hDEADBEEF, 32'd6});
    chk("mthi_no_busy", {63'h0, bus.busy}, 64'h0);
    op(3'd3, 1'b0, 32'hAAAA5555, 32'd0);
    op(3'd4, 1'b0, 32'h5555AAAA, 32'd0);
    chk("preload", {bus.hi, bus.lo}, 64'hAAAA5555_5555AAAA);
    op(3'd2, 1'b0, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    bus.cancel = 1'b1;
    op(3'd1, 1'b0, 32'd4, 32'd4);
    bus.cancel = 1'b0;
    chk("cancel_busy", {63'h0, bus.busy}, 64'h0);
    chk("cancel_hilo", {bus.hi, bus.lo}, 64'hAAAA5555_5555AAAA);
    repeat (4) begin @(posedge clk); #1; end
    chk("cancel_start_ignored", {63'h0, bus.busy}, 64'h0);
    op(3'd4, 1'b0, 32'h1234, 32'd0);
    chk("mtlo_after_cancel", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h1234});
`ifdef MD_MADD_EN
    op(3'd3, 1'b0, 32'h0, 32'd0);
    op(3'd4, 1'b0, 32'hFFFFFFFF, 32'd0);
    exp_q.push_back(64'h00000001_00000000);
    op(3'd5, 1'b0, 32'd1, 32'd1);
    wait_idle(n);
    chk("madd_latency", 64'(n), 64'd3);
    exp_q.push_back(64'h00000000_FFFFFFFF);
    op(3'd6, 1'b0, 32'd1, 32'd1);
    wait_idle(n);
`else
    op(3'd5, 1'b0, 32'd1, 32'd1);
    chk("madd_off_busy", {63'h0, bus.busy}, 64'h0);
    repeat (4) begin @(posedge clk); #1; end
    chk("madd_off_hilo", {bus.hi, bus.lo}, {32'hAAAA5555, 32'h1234});
`endif
    op(3'd1, 1'b0, 32'd2, 32'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("async_rst_busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("post_rst_idle", {bus.hi, bus.lo, 31'h0, bus.busy}, 96'h0);
    chk("all_commits_seen", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
